// File: rtl/comm_pkg.sv
// Shared types and helpers for the serial packet link: word geometry, FSM encodings and the
// baud divisor calculation.
package comm_pkg;

    localparam int unsigned WORD_W         = 136;
    localparam int unsigned BYTES_PER_WORD = WORD_W / 8;

    // Bit-level states of the byte serializer.
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} tx_state_t;

    // Packet-level states of the top: waiting, streaming bytes, end-of-packet pulse.
    typedef enum logic [1:0] {PKT_IDLE, PKT_SEND, PKT_DONE} pkt_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: one start bit, 8 data bits LSB first, one stop bit, each held for
// CLKS_PER_BIT cycles. A load in the final stop-bit cycle chains the next byte with no gap.
module uart_byte_tx
    import comm_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       TxD,
    output logic       byte_done
);

    localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sreg_q, sreg_d;
    logic             bit_end;

    assign bit_end = (baud_q == BAUD_MAX);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        sreg_d    = sreg_q;
        TxD       = 1'b1;
        byte_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    baud_d  = '0;
                    sreg_d  = byte_in;
                end
            end
            START: begin
                TxD = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                TxD = sreg_q[0];
                if (bit_end) begin
                    baud_d = '0;
                    sreg_d = {1'b0, sreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    byte_done = 1'b1;
                    baud_d    = '0;
                    if (load) begin
                        state_d = START;
                        sreg_d  = byte_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
        end
    end

endmodule

// File: rtl/uart_packet_tx.sv
// Packet transmitter: sends a WORD_W-bit word as WORD_W/8 back-to-back UART bytes, low byte first.
// Define PKT_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module uart_packet_tx
    import comm_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned WORD_W   = comm_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [WORD_W-1:0] tx_data,
    output logic              TxD,
    output logic              busy,
    output logic              tx_complete
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned NUM_DATA     = WORD_W / 8;
`ifdef PKT_CHECKSUM_EN
    localparam int unsigned NUM_BYTES    = NUM_DATA + 1;
    localparam logic [4:0]  LAST_DATA    = 5'(NUM_DATA - 1);
`else
    localparam int unsigned NUM_BYTES    = NUM_DATA;
`endif
    localparam logic [4:0]  LAST_BYTE    = 5'(NUM_BYTES - 1);

    pkt_state_t        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [4:0]        byte_cnt_q, byte_cnt_d;
    logic              load;
    logic [7:0]        byte_in;
    logic              byte_done;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // word_q holds the bytes not yet handed to the serializer; byte 0 goes straight from tx_data.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        byte_cnt_d  = byte_cnt_q;
        load        = 1'b0;
        byte_in     = 8'h00;
        busy        = 1'b0;
        tx_complete = 1'b0;
`ifdef PKT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            PKT_IDLE, PKT_DONE: begin
                tx_complete = (state_q == PKT_DONE);
                state_d     = PKT_IDLE;
                if (start) begin
                    load       = 1'b1;
                    byte_in    = tx_data[7:0];
                    word_d     = {8'h00, tx_data[WORD_W-1:8]};
                    byte_cnt_d = '0;
`ifdef PKT_CHECKSUM_EN
                    csum_d     = tx_data[7:0];
`endif
                    state_d    = PKT_SEND;
                end
            end
            PKT_SEND: begin
                busy = 1'b1;
                if (byte_done) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = PKT_DONE;
                    end else begin
                        load       = 1'b1;
                        byte_in    = word_q[7:0];
                        word_d     = word_q >> 8;
                        byte_cnt_d = byte_cnt_q + 5'd1;
`ifdef PKT_CHECKSUM_EN
                        csum_d     = csum_q ^ word_q[7:0];
                        if (byte_cnt_q == LAST_DATA) begin
                            byte_in = csum_q;
                        end
`endif
                    end
                end
            end
            default: state_d = PKT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= PKT_IDLE;
            word_q     <= '0;
            byte_cnt_q <= '0;
`ifdef PKT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
`ifdef PKT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .byte_in  (byte_in),
        .TxD      (TxD),
        .byte_done(byte_done)
    );

endmodule
